// File: rtl/multi_channel_frequency_drift.sv
// N-channel bounded random-walk frequency drift with per-sample jitter.
// Each channel walks on its own update period and drives a saturated omega_dt offset.
module multi_channel_frequency_drift #(
  parameter int          NCH        = 4,
  parameter int          WIDTH      = 18,
  parameter int          DRIFT_MAX  = 13,
  parameter int          JITTER_MAX = 5,
  parameter logic [15:0] SEED_BASE  = 16'hC3A7,
  parameter logic [15:0] JSEED_BASE = 16'h5E91
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  input  logic [NCH*WIDTH-1:0] omega_center,
  input  logic [NCH*22-1:0]    update_period,
  input  logic                 reflect_en,
  input  logic                 jitter_en,
  input  logic                 hold,
  input  logic                 recentre,
  output logic [NCH*WIDTH-1:0] drift,
  output logic [NCH*WIDTH-1:0] jitter,
  output logic [NCH*WIDTH-1:0] omega_actual,
  output logic [NCH-1:0]       update_strobe
);

  function automatic logic [15:0] seed_of(input logic [15:0] base, input int k);
    logic [31:0] prod;
    logic [15:0] s;
    prod = k * 32'h9E37;
    s    = base ^ prod[15:0];
    return (s == 16'h0000) ? 16'h0001 : s;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic signed [WIDTH-1:0] init_of(input logic [15:0] s);
    int t;
    t = (int'(s[15:11]) - 16) * DRIFT_MAX;
    return WIDTH'(t >>> 4);
  endfunction

  // Out-of-range steps either pin to the bound or fold back inside it.
  function automatic logic signed [WIDTH-1:0] walk(input logic signed [WIDTH-1:0] d,
                                                   input logic [15:0] l, input logic refl);
    int n;
    int st;
    st = l[1] ? 2 : 1;
    n  = l[0] ? int'(d) + st : int'(d) - st;
    if (n > DRIFT_MAX)       n = refl ? 2 * DRIFT_MAX - n : DRIFT_MAX;
    else if (n < -DRIFT_MAX) n = refl ? -2 * DRIFT_MAX - n : -DRIFT_MAX;
    return WIDTH'(n);
  endfunction

  function automatic logic signed [WIDTH-1:0] jit_of(input logic [15:0] j);
    int r;
    r = (j[1] ? 3 : -3) + (j[0] ? 2 : -2);
    if (r > JITTER_MAX)       r = JITTER_MAX;
    else if (r < -JITTER_MAX) r = -JITTER_MAX;
    return WIDTH'(r);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] s);
    if (s[WIDTH+1:WIDTH-1] == 3'b000 || s[WIDTH+1:WIDTH-1] == 3'b111) return s[WIDTH-1:0];
    else if (s[WIDTH+1])                                              return {1'b1, {(WIDTH-1){1'b0}}};
    else                                                              return {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    localparam logic [15:0]             DSEED = seed_of(SEED_BASE, k);
    localparam logic [15:0]             JSEED = seed_of(JSEED_BASE, k);
    localparam logic signed [WIDTH-1:0] DINIT = init_of(DSEED);

    logic [21:0]             cnt_p0;
    logic [15:0]             dl_p0;
    logic [15:0]             jl_p0;
    logic signed [WIDTH-1:0] drift_p0;
    logic signed [WIDTH-1:0] jit_p0;
    logic signed [WIDTH-1:0] omega_p1;
    logic                    vld_p1;
    logic signed [WIDTH-1:0] ctr;
    logic [21:0]             per;
    logic                    tick;
    logic signed [WIDTH+1:0] sum_p0;

    assign ctr    = omega_center[k*WIDTH +: WIDTH];
    assign per    = update_period[k*22 +: 22];
    assign tick   = (cnt_p0 >= per);
    assign sum_p0 = {{2{ctr[WIDTH-1]}}, ctr} + {{2{drift_p0[WIDTH-1]}}, drift_p0}
                  + {{2{jit_p0[WIDTH-1]}}, jit_p0};

    // Stage p0: walk/jitter state on clk_en; stage p1: saturated sum every clk
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_p0   <= '0;
        dl_p0    <= DSEED;
        jl_p0    <= JSEED;
        drift_p0 <= DINIT;
        jit_p0   <= '0;
        omega_p1 <= '0;
        vld_p1   <= 1'b0;
      end else begin
        omega_p1 <= sat(sum_p0);
        vld_p1   <= 1'b0;
        if (clk_en) begin
          jl_p0  <= lfsr_next(jl_p0);
          jit_p0 <= jitter_en ? jit_of(lfsr_next(jl_p0)) : '0;
        end
        if (recentre) begin
          drift_p0 <= '0;
          cnt_p0   <= '0;
        end else if (clk_en && !hold) begin
          if (tick) begin
            cnt_p0   <= '0;
            dl_p0    <= lfsr_next(dl_p0);
            drift_p0 <= walk(drift_p0, dl_p0, reflect_en);
            vld_p1   <= 1'b1;
          end else begin
            cnt_p0 <= cnt_p0 + 22'd1;
          end
        end
      end
    end

    assign drift[k*WIDTH +: WIDTH]        = drift_p0;
    assign jitter[k*WIDTH +: WIDTH]       = jit_p0;
    assign omega_actual[k*WIDTH +: WIDTH] = omega_p1;
    assign update_strobe[k]               = vld_p1;
  end

endmodule

// File: tb/tb_multi_channel_frequency_drift.sv
// Directed bench for multi_channel_frequency_drift: walk timing, bounds, hold/recentre,
// jitter gating and output saturation, with hand-derived expected values.
module tb_multi_channel_frequency_drift;
  localparam int W = 18;
  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, clk_en, reflect_en, jitter_en, hold, recentre;
  logic [N*W-1:0] omega_center, drift, jitter, omega_actual;
  logic [N*22-1:0] update_period;
  logic [N-1:0]   update_strobe;

  logic [W-1:0]   d2_center, d2_drift, d2_jitter, d2_omega;
  logic [21:0]    d2_period;
  logic [0:0]     d2_strobe;

  int checks = 0;
  int errors = 0;

  multi_channel_frequency_drift #(.NCH(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .omega_center(omega_center),
    .update_period(update_period), .reflect_en(reflect_en), .jitter_en(jitter_en),
    .hold(hold), .recentre(recentre), .drift(drift), .jitter(jitter),
    .omega_actual(omega_actual), .update_strobe(update_strobe)
  );

  multi_channel_frequency_drift #(.NCH(1), .WIDTH(W), .DRIFT_MAX(2)) dut2 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .omega_center(d2_center),
    .update_period(d2_period), .reflect_en(reflect_en), .jitter_en(jitter_en),
    .hold(hold), .recentre(recentre), .drift(d2_drift), .jitter(d2_jitter),
    .omega_actual(d2_omega), .update_strobe(d2_strobe)
  );

  function automatic logic signed [31:0] dr(input int k);
    return $signed(drift[k*W +: W]);
  endfunction
  function automatic logic signed [31:0] jt(input int k);
    return $signed(jitter[k*W +: W]);
  endfunction
  function automatic logic signed [31:0] om(input int k);
    return $signed(omega_actual[k*W +: W]);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic en_pulse();
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic set_p(input int k, input logic [21:0] v);
    update_period[k*22 +: 22] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic signed [31:0] seq [N][64];
  int sc, jc, rv, jv, sv, same;
  logic signed [31:0] jprev;

  initial begin
    rst = 1'b1; clk_en = 1'b0; reflect_en = 1'b0; jitter_en = 1'b1;
    hold = 1'b0; recentre = 1'b0;
    omega_center = '0; d2_center = '0; d2_period = '0;
    for (int k = 0; k < N; k++) set_p(k, 22'd1000);
    set_p(0, 22'd3);

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_drift0", dr(0), 6);
    chk("rst_drift1", dr(1), -5);
    chk("rst_drift2", dr(2), 12);
    chk("rst_drift3", dr(3), -11);
    chk("rst_jitter0", jt(0), 0);
    chk("rst_omega0", om(0), 0);
    chk("rst_strobe", {28'd0, update_strobe}, 0);
    rst = 1'b0;

    // P_0 = 3: update on the 4th enable, 6 -> 8
    en_pulse();
    chk("jit0_e1", jt(0), 1);
    chk("drift0_e1", dr(0), 6);
    en_pulse();
    chk("jit0_e2", jt(0), -5);
    en_pulse();
    chk("drift0_e3", dr(0), 6);
    chk("strobe0_e3", {31'd0, update_strobe[0]}, 0);
    en_pulse();
    chk("drift0_e4", dr(0), 8);
    chk("strobe0_e4", {31'd0, update_strobe[0]}, 1);
    chk("jit0_e4", jt(0), -5);
    chk("omega0_lag", om(0), 1);
    @(negedge clk);
    chk("strobe0_once", {31'd0, update_strobe[0]}, 0);
    chk("omega0_sum", om(0), 3);

    // Counter at 100, period lowered 5000 -> 10
    set_p(0, 22'd5000);
    clk_en = 1'b1;
    repeat (100) @(negedge clk);
    clk_en = 1'b0;
    chk("drift0_cnt100", dr(0), 8);
    set_p(0, 22'd10);
    en_pulse();
    chk("drift0_plower", dr(0), 10);
    chk("strobe0_plower", {31'd0, update_strobe[0]}, 1);
    sc = 0;
    for (int i = 0; i < 10; i++) begin
      en_pulse();
      sc += int'(update_strobe[0]);
    end
    chk("strobes_after_plower", sc, 0);
    en_pulse();
    chk("drift0_p10_tick", dr(0), 8);
    chk("strobe0_p10_tick", {31'd0, update_strobe[0]}, 1);

    // Hold freezes walk and counter, jitter keeps running
    repeat (5) en_pulse();
    hold = 1'b1;
    sc = 0; jc = 0; jprev = jt(0);
    for (int i = 0; i < 20; i++) begin
      en_pulse();
      sc += int'(update_strobe[0]);
      if (jt(0) != jprev) jc++;
      jprev = jt(0);
    end
    chk("hold_strobes", sc, 0);
    chk("hold_drift0", dr(0), 8);
    chk("hold_jitter_moves", (jc > 0) ? 1 : 0, 1);
    hold = 1'b0;
    sc = 0;
    repeat (5) begin
      en_pulse();
      sc += int'(update_strobe[0]);
    end
    chk("post_hold_strobes", sc, 0);
    en_pulse();
    chk("post_hold_drift0", dr(0), 9);

    // Recentre together with hold zeroes every walk and counter
    repeat (3) en_pulse();
    hold = 1'b1; recentre = 1'b1;
    en_pulse();
    recentre = 1'b0; hold = 1'b0;
    for (int k = 0; k < N; k++) chk($sformatf("recentre_drift%0d", k), dr(k), 0);
    chk("recentre_no_strobe", {28'd0, update_strobe}, 0);
    sc = 0;
    repeat (10) begin
      en_pulse();
      sc += int'(update_strobe[0]);
    end
    chk("recentre_cnt_strobes", sc, 0);
    en_pulse();
    chk("recentre_first_tick", dr(0), -2);

    // Output saturation and jitter gating
    omega_center[0*W +: W] = 18'h1FFFF;
    omega_center[1*W +: W] = 18'd1000;
    omega_center[3*W +: W] = 18'h20000;
    for (int k = 0; k < N; k++) set_p(k, 22'd1000);
    do_reset();
    @(negedge clk);
    chk("sat_hi", om(0), 131071);
    chk("sat_lo", om(3), -131072);
    chk("nosat_ch1", om(1), 995);
    en_pulse();
    chk("jit0_after_rst", jt(0), 1);
    chk("jit1_after_rst", jt(1), -1);
    @(negedge clk);
    chk("sat_hi_jit", om(0), 131071);
    chk("nosat_ch1_jit", om(1), 994);
    jitter_en = 1'b0;
    en_pulse();
    chk("jit0_gated", jt(0), 0);
    chk("jit1_gated", jt(1), 0);
    jitter_en = 1'b1;

    // DRIFT_MAX = 2: clamp vs reflect on the first tick
    reflect_en = 1'b0;
    do_reset();
    chk("d2_init", $signed(d2_drift), 1);
    en_pulse();
    chk("d2_clamp", $signed(d2_drift), 2);
    chk("d2_strobe", {31'd0, d2_strobe[0]}, 1);
    en_pulse();
    chk("d2_clamp2", $signed(d2_drift), 2);
    reflect_en = 1'b1;
    do_reset();
    en_pulse();
    chk("d2_reflect", $signed(d2_drift), 1);
    en_pulse();
    chk("d2_reflect2", $signed(d2_drift), 1);

    // All channels updating every enable
    omega_center = '0;
    for (int k = 0; k < N; k++) set_p(k, 22'd0);
    reflect_en = 1'b0;
    do_reset();
    rv = 0; jv = 0; sv = 0;
    for (int i = 0; i < 64; i++) begin
      if (i == 32) reflect_en = 1'b1;
      en_pulse();
      if (update_strobe != 4'hF) sv++;
      for (int k = 0; k < N; k++) begin
        seq[k][i] = dr(k);
        if (dr(k) > 13 || dr(k) < -13) rv++;
        if (!(jt(k) == 1 || jt(k) == -1 || jt(k) == 5 || jt(k) == -5)) jv++;
      end
    end
    chk("all_first_ch0", seq[0][0], 8);
    chk("all_first_ch1", seq[1][0], -6);
    chk("all_first_ch2", seq[2][0], 13);
    chk("all_first_ch3", seq[3][0], -13);
    chk("all_range", rv, 0);
    chk("all_jitter_set", jv, 0);
    chk("all_strobes", sv, 0);
    for (int a = 0; a < N; a++) begin
      for (int b = a + 1; b < N; b++) begin
        same = 1;
        for (int i = 0; i < 64; i++) if (seq[a][i] != seq[b][i]) same = 0;
        chk($sformatf("distinct_%0d_%0d", a, b), same, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_channel_frequency_drift.md
# multi_channel_frequency_drift

Parametrised, N-channel generator of bounded random-walk frequency drift plus per-sample jitter, producing `omega_dt` offsets for a bank of oscillators (theta, alpha, SR harmonics, …) from one instance. Each channel has its own runtime update period, which provides seeker/reference rate ratios, and its own LFSR pair. The block adds clamp-or-reflect boundaries, hold, recentre and jitter gating. It sits between the oscillator bank and the alignment/ignition detectors, on the 4 kHz `clk_en` sample strobe.

## Interface
- `NCH`, 4, number of channels (1–16)
- `WIDTH`, 18, signed omega word width (Q·14 fixed point)
- `DRIFT_MAX`, 13, walk bound ±DRIFT_MAX, ≥2 (13 ≈ ±0.5 Hz)
- `JITTER_MAX`, 5, jitter clamp ±JITTER_MAX, ≥1
- `SEED_BASE`, 16'hC3A7, drift LFSR base seed
- `JSEED_BASE`, 16'h5E91, jitter LFSR base seed
- `clk` in 1: single clock
- `rst` in 1: synchronous, active-high reset
- `clk_en` in 1: sample strobe
- `omega_center` in NCH*WIDTH: per-channel signed centre; channel k is at bits [k*WIDTH +: WIDTH]
- `update_period` in NCH*22: per-channel update period P_k, unsigned
- `reflect_en` in 1: 1 = reflecting boundaries, 0 = saturating
- `jitter_en` in 1: 0 forces jitter to 0
- `hold` in 1: freeze the walk
- `recentre` in 1: single-cycle pulse that zeroes every walk
- `drift` out NCH*WIDTH: registered drift_reg per channel
- `jitter` out NCH*WIDTH: registered jitter per channel
- `omega_actual` out NCH*WIDTH: registered, saturated centre+drift+jitter
- `update_strobe` out NCH: one-clk pulse per channel update

## Operation
Channel seeds:
- drift S_k = SEED_BASE ^ (k·16'h9E37)
- jitter J_k = JSEED_BASE ^ (k·16'h9E37)
- A seed that comes out as 0 is replaced by 16'h0001.

LFSRs are 16-bit Fibonacci, shift left: next = {l[14:0], l[15]^l[13]^l[12]^l[10]}.

Init offset:
- init_k = ((S_k[15:11] − 16)·DRIFT_MAX) >>> 4, signed arithmetic.
- Channel 0 with defaults: (24−16)·13 >>> 4 = 6.

Update counter (per channel, 22-bit):
- On each clk_en with hold=0, tick_k = (cnt_k ≥ P_k).
- On tick the counter goes to 0; otherwise it increments.
- An update therefore occurs every P_k+1 enables. P_k=0 gives an update every clk_en.
- If P_k is lowered below cnt_k, the tick fires on the next enable.

On tick_k:
- Drift LFSR advances.
- Direction is dir = l[0] from the pre-shift value; step = l[1] ? 2 : 1, also pre-shift.
- n = drift ± step.
- If n > DRIFT_MAX: drift = DRIFT_MAX when clamping, 2·DRIFT_MAX − n when reflecting.
- If n < −DRIFT_MAX: drift = −DRIFT_MAX when clamping, −2·DRIFT_MAX − n when reflecting.
- Otherwise drift = n.

Jitter (per channel):
- The jitter LFSR advances on every clk_en, regardless of hold or jitter_en.
- raw = (j[1] ? +3 : −3) + (j[0] ? +2 : −2), using post-shift bits. This gives values in {−5, −1, 1, 5}.
- raw is clamped to ±JITTER_MAX and registered on clk_en.
- When jitter_en=0, 0 is registered instead.

Output sum:
- Computed in WIDTH+2 bits every clk as centre + drift + jitter.
- Saturated to the signed WIDTH range [−2^(WIDTH−1), 2^(WIDTH−1)−1].

Priority: rst > recentre > hold > normal.
- recentre: all drift=0, all cnt=0, LFSRs untouched, no strobe.
- hold (with clk_en): counters, drift LFSRs and drift frozen, no strobe; jitter continues.

## Timing
- Reset values:
  - `drift` = init_k
  - `jitter` = 0
  - `omega_actual` = 0
  - `update_strobe` = 0
  - counters = 0
  - LFSRs = S_k / J_k
- The drift register updates at the clk edge where clk_en & tick_k. `update_strobe[k]` is high for exactly the following clk cycle.
- `omega_actual` lags drift/jitter/centre by 1 clk; it is registered every clk, not gated by clk_en.
- First update after reset occurs on the (P_k+1)-th clk_en.
- Channels are fully independent; simultaneous ticks on all channels are legal.
- Reset asserted mid-operation restores all reset values at the next edge.

## Test plan
- Reset, defaults, P_0=3, 4 clk_en pulses → `drift[0]` goes 6 → 8 on the 4th enable (C3A7: dir=1, step=2). `update_strobe[0]` pulses once, 1 clk later.
- DRIFT_MAX=2, channel 0, first tick → init 1, n=3. reflect_en=0 gives `drift`=2; reflect_en=1 gives `drift`=1.
- cnt_0 at 100, P_0 changed 5000→10 → tick on the next clk_en, counter returns to 0, strobe fires.
- hold=1 for 20 enables → drift and counter unchanged, no strobes, `jitter` still changing. Then recentre pulse together with hold → all drift=0, cnt=0.
- omega_center[0]=131071, drift positive, jitter_en=1 → `omega_actual[0]`=131071, saturated with no wrap. jitter_en=0 → `jitter`=0 from the next enable.
- NCH=4, all P=0, 64 enables → each channel stays within ±13, channel sequences differ, and each |jitter| ∈ {1, 5}.
